keycode_sequencer: RTL and testbench

KEYCODE_SEQUENCER -- requirements
Module: keycode_sequencer

---
 rtl/keycode_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_keycode_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keycode_sequencer.sv
// Scripted keycode player: stores {keycode, hold} entries and replays them one
// frame per clock, with optional blank gap frames between entries and looping.
module keycode_sequencer #(
  parameter int DEPTH      = 8,
  parameter int GAP_FRAMES = 1
) (
  input  logic                     frame_clk,
  input  logic                     Reset,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [7:0]               wr_keycode,
  input  logic [7:0]               wr_hold,
  input  logic                     clear,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     loop,
  output logic [7:0]               keycode,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Shared hold/gap timer; wide enough for a full 255-frame hold or the gap.
  localparam int TW = (GAP_FRAMES > 255) ? $clog2(GAP_FRAMES + 1) : 8;

  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, GAP = 2'd2} state_t;

  function automatic logic [TW-1:0] hold_frames(input logic [7:0] hold);
    if (hold == 8'd0) begin
      hold_frames = TW'(1'b1);
    end else begin
      hold_frames = TW'(hold);
    end
  endfunction

  state_t        state_r, state_s, eoe_state_s;
  logic [IW-1:0] idx_r, idx_s, eoe_idx_s, nxt_idx_s;
  logic [TW-1:0] timer_r, timer_s, eoe_timer_s;
  logic [CW-1:0] count_r;
  logic [7:0]    keycode_r, keycode_s;
  logic          busy_r, done_r, done_s, eoe_done_s;
  logic          last_s, wr_ready_s;
  logic [7:0]    mem_kc_r   [DEPTH];
  logic [7:0]    mem_hold_r [DEPTH];

  // Write acceptance: only while idle, not full, and not being cleared.
  always_comb begin
    wr_ready_s = (state_r == IDLE) && (count_r < CW'(DEPTH)) && !clear;
  end

  // End-of-entry decision: advance, wrap on loop, or finish with done.
  always_comb begin
    last_s      = (CW'(idx_r) + CW'(1'b1)) >= count_r;
    nxt_idx_s   = last_s ? {IW{1'b0}} : (idx_r + IW'(1'b1));
    eoe_state_s = PLAY;
    eoe_idx_s   = nxt_idx_s;
    eoe_timer_s = hold_frames(mem_hold_r[nxt_idx_s]);
    eoe_done_s  = 1'b0;
    if (last_s && !loop) begin
      eoe_state_s = IDLE;
      eoe_idx_s   = {IW{1'b0}};
      eoe_timer_s = {TW{1'b0}};
      eoe_done_s  = 1'b1;
    end else begin
      eoe_done_s  = 1'b0;
    end
  end

  // Playback FSM next state; stop outranks start and end-of-entry.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    timer_s = timer_r;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start && !stop && !clear && (count_r != {CW{1'b0}})) begin
          state_s = PLAY;
          idx_s   = {IW{1'b0}};
          timer_s = hold_frames(mem_hold_r[0]);
        end else begin
          timer_s = {TW{1'b0}};
        end
      end
      PLAY: begin
        if (stop) begin
          state_s = IDLE;
          idx_s   = {IW{1'b0}};
          timer_s = {TW{1'b0}};
        end else if (timer_r <= TW'(1'b1)) begin
          if (GAP_FRAMES != 0) begin
            state_s = GAP;
            timer_s = TW'(GAP_FRAMES);
          end else begin
            state_s = eoe_state_s;
            idx_s   = eoe_idx_s;
            timer_s = eoe_timer_s;
            done_s  = eoe_done_s;
          end
        end else begin
          timer_s = timer_r - TW'(1'b1);
        end
      end
      GAP: begin
        if (stop) begin
          state_s = IDLE;
          idx_s   = {IW{1'b0}};
          timer_s = {TW{1'b0}};
        end else if (timer_r <= TW'(1'b1)) begin
          state_s = eoe_state_s;
          idx_s   = eoe_idx_s;
          timer_s = eoe_timer_s;
          done_s  = eoe_done_s;
        end else begin
          timer_s = timer_r - TW'(1'b1);
        end
      end
      default: begin
        state_s = IDLE;
        idx_s   = {IW{1'b0}};
        timer_s = {TW{1'b0}};
      end
    endcase
  end

  // Keycode for the coming frame, derived from the next state.
  always_comb begin
    if (state_s == PLAY) begin
      keycode_s = mem_kc_r[idx_s];
    end else begin
      keycode_s = 8'h00;
    end
  end

  // FSM and registered outputs.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_r   <= IDLE;
      idx_r     <= {IW{1'b0}};
      timer_r   <= {TW{1'b0}};
      keycode_r <= 8'h00;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      idx_r     <= idx_s;
      timer_r   <= timer_s;
      keycode_r <= keycode_s;
      busy_r    <= (state_s != IDLE);
      done_r    <= done_s;
    end
  end

  // Entry count; clear only acts while idle and beats a same-cycle write.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      count_r <= {CW{1'b0}};
    end else if ((state_r == IDLE) && clear) begin
      count_r <= {CW{1'b0}};
    end else if (wr_valid && wr_ready_s) begin
      count_r <= count_r + CW'(1'b1);
    end else begin
      count_r <= count_r;
    end
  end

  // Script storage; contents survive playback and need no reset.
  always_ff @(posedge frame_clk) begin
    if (!Reset && wr_valid && wr_ready_s) begin
      mem_kc_r[count_r[IW-1:0]]   <= wr_keycode;
      mem_hold_r[count_r[IW-1:0]] <= wr_hold;
    end
  end

  assign wr_ready = wr_ready_s;
  assign keycode  = keycode_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign count    = count_r;

endmodule

// File: tb/tb_keycode_sequencer.sv
// Bench for keycode_sequencer: two instances (gap 1 and gap 0) share stimulus and are
// checked every cycle against a frame-list model, plus hand-computed literal checks.
module tb_keycode_sequencer;

  logic       frame_clk = 1'b0;
  logic       Reset = 1'b1;
  logic       wr_valid = 1'b0, clear = 1'b0, start = 1'b0, stop = 1'b0, loop_i = 1'b0;
  logic [7:0] wr_keycode = 8'h00, wr_hold = 8'h00;

  logic       wr_ready_o [2];
  logic [7:0] keycode_o  [2];
  logic       busy_o     [2];
  logic       done_o     [2];
  logic [3:0] count_o    [2];

  int n_checks = 0;
  int n_fail   = 0;

  keycode_sequencer #(.DEPTH(8), .GAP_FRAMES(1)) dut_g1 (
    .frame_clk(frame_clk), .Reset(Reset), .wr_valid(wr_valid), .wr_ready(wr_ready_o[0]),
    .wr_keycode(wr_keycode), .wr_hold(wr_hold), .clear(clear), .start(start), .stop(stop),
    .loop(loop_i), .keycode(keycode_o[0]), .busy(busy_o[0]), .done(done_o[0]), .count(count_o[0]));

  keycode_sequencer #(.DEPTH(8), .GAP_FRAMES(0)) dut_g0 (
    .frame_clk(frame_clk), .Reset(Reset), .wr_valid(wr_valid), .wr_ready(wr_ready_o[1]),
    .wr_keycode(wr_keycode), .wr_hold(wr_hold), .clear(clear), .start(start), .stop(stop),
    .loop(loop_i), .keycode(keycode_o[1]), .busy(busy_o[1]), .done(done_o[1]), .count(count_o[1]));

  always #5 frame_clk = ~frame_clk;

  // Model: on start the whole pass is expanded into a list of frames to show.
  int         mcount [2];
  logic [7:0] mkc    [2][8];
  logic [7:0] mhold  [2][8];
  bit         playing[2];
  logic [7:0] frames [2][2048];
  int         flen   [2];
  int         fpos   [2];
  logic [7:0] ekc    [2];
  bit         ebusy  [2];
  bit         edone  [2];
  bit         model_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic build(input int m);
    int g;
    int h;
    g = (m == 0) ? 1 : 0;
    flen[m] = 0;
    fpos[m] = 0;
    for (int i = 0; i < mcount[m]; i++) begin
      h = (mhold[m][i] == 8'd0) ? 1 : int'(mhold[m][i]);
      for (int j = 0; j < h; j++) begin frames[m][flen[m]] = mkc[m][i]; flen[m]++; end
      for (int j = 0; j < g; j++) begin frames[m][flen[m]] = 8'h00; flen[m]++; end
    end
  endtask

  task automatic model_step(input int m);
    bit ready;
    if (Reset) begin
      mcount[m] = 0; playing[m] = 1'b0; ekc[m] = 8'h00; ebusy[m] = 1'b0; edone[m] = 1'b0;
    end else begin
      edone[m] = 1'b0;
      if (playing[m]) begin
        if (stop) begin
          playing[m] = 1'b0; ekc[m] = 8'h00;
        end else if (fpos[m] < flen[m]) begin
          ekc[m] = frames[m][fpos[m]]; fpos[m]++;
        end else if (loop_i) begin
          build(m); ekc[m] = frames[m][fpos[m]]; fpos[m]++;
        end else begin
          playing[m] = 1'b0; ekc[m] = 8'h00; edone[m] = 1'b1;
        end
      end else begin
        ready = (mcount[m] < 8) && !clear;
        if (start && !stop && !clear && mcount[m] > 0) begin
          build(m); playing[m] = 1'b1; ekc[m] = frames[m][fpos[m]]; fpos[m]++;
        end
        if (clear) begin
          mcount[m] = 0;
        end else if (wr_valid && ready) begin
          mkc[m][mcount[m]] = wr_keycode; mhold[m][mcount[m]] = wr_hold; mcount[m]++;
        end
      end
      ebusy[m] = playing[m];
    end
  endtask

  initial forever begin
    @(posedge frame_clk);
    if (Reset) model_on = 1'b1;
    model_step(0);
    model_step(1);
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge frame_clk);
    if (model_on) begin
      for (int m = 0; m < 2; m++) begin
        check($sformatf("keycode[%0d]", m), keycode_o[m], ekc[m]);
        check($sformatf("busy[%0d]", m), busy_o[m], ebusy[m]);
        check($sformatf("done[%0d]", m), done_o[m], edone[m]);
        check($sformatf("count[%0d]", m), count_o[m], mcount[m]);
        check($sformatf("wr_ready[%0d]", m), wr_ready_o[m],
              (!playing[m] && mcount[m] < 8 && !clear) ? 1 : 0);
      end
    end
  end

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic write(input logic [7:0] k, input logic [7:0] h);
    wr_valid = 1'b1; wr_keycode = k; wr_hold = h;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while ((busy_o[0] || busy_o[1]) && n < bound) begin tick(); n++; end
    check("idle_timeout", {31'd0, busy_o[0] | busy_o[1]}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp33 [7];
    int n;
    exp33 = '{8'h1A, 8'h1A, 8'h1A, 8'h00, 8'h07, 8'h07, 8'h00};

    repeat (2) tick();
    Reset = 1'b0;
    check("rst_keycode", keycode_o[0], 8'h00);
    check("rst_busy", busy_o[0], 0);
    check("rst_done", done_o[0], 0);
    check("rst_count", count_o[0], 0);
    check("rst_wr_ready", wr_ready_o[0], 1);

    // Two-entry script with one gap frame.
    write(8'h1A, 8'd3);
    write(8'h07, 8'd2);
    pulse_start();
    for (int i = 0; i < 7; i++) begin
      check($sformatf("seq33_t%0d", i + 1), keycode_o[0], exp33[i]);
      tick();
    end
    check("seq33_done", done_o[0], 1);
    check("seq33_busy", busy_o[0], 0);
    wait_idle(20);

    // Fill to DEPTH with wr_valid held high, play it, then overflow and clear.
    clear = 1'b1; tick(); clear = 1'b0;
    check("clr_count", count_o[0], 0);
    wr_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wr_keycode = 8'h10 + 8'(i); wr_hold = 8'(i);
      tick();
    end
    wr_keycode = 8'hEE; wr_hold = 8'd9;
    check("full_wr_ready", wr_ready_o[0], 0);
    check("full_count", count_o[0], 8);
    tick();
    wr_valid = 1'b0;
    check("drop_count", count_o[0], 8);
    pulse_start();
    wait_idle(200);
    clear = 1'b1; tick(); clear = 1'b0;
    check("clear8_count", count_o[0], 0);

    // Single zero-hold entry looping; gap-0 instance shows it every frame.
    write(8'h04, 8'd0);
    loop_i = 1'b1;
    pulse_start();
    for (int i = 0; i < 6; i++) begin
      check("loop_kc", keycode_o[1], 8'h04);
      check("loop_busy", busy_o[1], 1);
      check("loop_done", done_o[1], 0);
      tick();
    end
    pulse_start();
    clear = 1'b1; tick(); clear = 1'b0;
    check("busy_clear_ignored", count_o[1], 1);
    loop_i = 1'b0;
    tick();
    check("unloop_done", done_o[1], 1);
    check("unloop_busy", busy_o[1], 0);
    wait_idle(10);

    // Stop part-way through a hold, then replay from the beginning.
    clear = 1'b1; tick(); clear = 1'b0;
    write(8'h16, 8'd10);
    pulse_start();
    repeat (3) tick();
    stop = 1'b1; tick(); stop = 1'b0;
    check("stop_kc", keycode_o[0], 8'h00);
    check("stop_busy", busy_o[0], 0);
    check("stop_done", done_o[0], 0);
    pulse_start();
    repeat (9) tick();
    check("replay_f10", keycode_o[0], 8'h16);
    tick();
    check("replay_f11", keycode_o[0], 8'h00);
    wait_idle(10);

    // Empty start, stop+start in idle, then Reset during playback with start high.
    clear = 1'b1; tick(); clear = 1'b0;
    pulse_start();
    check("empty_busy", busy_o[0], 0);
    check("empty_done", done_o[0], 0);
    write(8'h1A, 8'd5);
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    check("stop_beats_start", busy_o[0], 0);
    pulse_start();
    tick();
    Reset = 1'b1; start = 1'b1;
    tick();
    check("rstplay_kc", keycode_o[0], 8'h00);
    check("rstplay_busy", busy_o[0], 0);
    check("rstplay_count", count_o[0], 0);
    Reset = 1'b0; start = 1'b0;

    // Maximum hold.
    write(8'h1A, 8'd255);
    pulse_start();
    n = 0;
    while (keycode_o[0] == 8'h1A && n < 300) begin n++; tick(); end
    check("hold255_len", n, 255);
    check("hold255_after", keycode_o[0], 8'h00);
    wait_idle(20);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
